// File: rtl/ball_collision_detect_if.sv
`default_nettype none
// ============================================================================
//  Module      : ball_collision_detect_if
//  Description : Pixel/ball stream bundle between the raster source, the
//                motion block and the ball collision detector.
//  Revision    : 1.0  initial release
// ============================================================================
interface ball_collision_detect_if;
  // Raster and ball position toward the detector
  logic       frame_pulse;
  logic       pixel_valid;
  logic [9:0] pixel_x;
  logic [8:0] pixel_y;
  logic       solid;
  logic [9:0] ball_x;
  logic [8:0] ball_y;

  // Per-pixel results from the detector
  logic       ball_pixel;
  logic       collision;
  logic       ball_top_col;
  logic       ball_bottom_col;
  logic       ball_left_col;
  logic       ball_right_col;

  modport master (
    output frame_pulse, pixel_valid, pixel_x, pixel_y, solid, ball_x, ball_y,
    input  ball_pixel, collision, ball_top_col, ball_bottom_col,
           ball_left_col, ball_right_col
  );

  modport slave (
    input  frame_pulse, pixel_valid, pixel_x, pixel_y, solid, ball_x, ball_y,
    output ball_pixel, collision, ball_top_col, ball_bottom_col,
           ball_left_col, ball_right_col
  );
endinterface
`default_nettype wire

// File: rtl/ball_collision_detect.sv
`default_nettype none
// ============================================================================
//  Module      : ball_collision_detect
//  Description : Pixel-rate ball/playfield collision detector. Two-stage
//                pipeline against a frame-stable shadow of the ball position,
//                producing the ball pixel, a collision strobe and per-edge
//                collision flags. Collisions are suppressed for a short window
//                around frame_pulse while the motion block clears its latches.
//  Options     : BALL_COL_CORNER_MASK_EN - when defined, the four corner
//                pixels are removed from the ball (rounded ball).
//  Revision    : 1.0  initial release
// ============================================================================
module ball_collision_detect #(
  parameter int BALL_SIZE = 4   // ball width/height in pixels, 2..8
) (
  input  logic                   clk,
  input  logic                   nRst,
  ball_collision_detect_if.slave bus
);

  localparam logic [10:0] C_SIZE_X = 11'(BALL_SIZE);
  localparam logic [10:0] C_LAST_X = 11'(BALL_SIZE - 1);
  localparam logic [9:0]  C_SIZE_Y = 10'(BALL_SIZE);
  localparam logic [9:0]  C_LAST_Y = 10'(BALL_SIZE - 1);

  // Frame pulse history: fp1 is the cycle the shadow loads, fp2/fp3 extend
  // the blanking window over the pipeline depth.
  logic       fp1_q, fp2_q, fp3_q;
  logic [9:0] sx_q;
  logic [8:0] sy_q;

  // Stage 1 registers
  logic hit1_q, solid1_q, et1_q, eb1_q, el1_q, er1_q;

  // Stage 2 (output) registers
  logic ball_pixel_q, collision_q, top_q, bottom_q, left_q, right_q;

  // Stage 1 combinational terms
  logic [10:0] dx;
  logic [9:0]  dy;
  logic        in_x, in_y;
  logic        e_t, e_b, e_l, e_r;
  logic        corner;
  logic        hit1_d;

  // Stage 2 combinational terms
  logic        blank;
  logic        collision_d;

  // Offset of the raster from the shadow position; the top bit is the borrow,
  // so a raster left of / above the ball can never fall inside the box and
  // a ball running off the right/bottom edge is clipped rather than wrapped.
  assign dx   = {1'b0, bus.pixel_x} - {1'b0, sx_q};
  assign dy   = {1'b0, bus.pixel_y} - {1'b0, sy_q};
  assign in_x = ~dx[10] & (dx < C_SIZE_X);
  assign in_y = ~dy[9]  & (dy < C_SIZE_Y);
  assign e_t  = (dy == 10'd0);
  assign e_b  = (dy == C_LAST_Y);
  assign e_l  = (dx == 11'd0);
  assign e_r  = (dx == C_LAST_X);

`ifdef BALL_COL_CORNER_MASK_EN
  // A corner pixel is one where a row edge and a column edge coincide.
  assign corner = (e_t | e_b) & (e_l | e_r);
`else
  assign corner = 1'b0;
`endif

  assign hit1_d      = bus.pixel_valid & in_x & in_y & ~corner;
  assign blank       = bus.frame_pulse | fp1_q | fp2_q | fp3_q;
  assign collision_d = hit1_q & solid1_q & ~blank;

  // Frame pulse delay line and shadow position load on the delayed pulse
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      fp1_q <= 1'b0;
      fp2_q <= 1'b0;
      fp3_q <= 1'b0;
      sx_q  <= 10'd0;
      sy_q  <= 9'd0;
    end else begin
      fp1_q <= bus.frame_pulse;
      fp2_q <= fp1_q;
      fp3_q <= fp2_q;
      if (fp1_q) begin
        sx_q <= bus.ball_x;
        sy_q <= bus.ball_y;
      end
    end
  end

  // Stage 1: box membership, edge flags and the aligned solid bit
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      hit1_q   <= 1'b0;
      solid1_q <= 1'b0;
      et1_q    <= 1'b0;
      eb1_q    <= 1'b0;
      el1_q    <= 1'b0;
      er1_q    <= 1'b0;
    end else begin
      hit1_q   <= hit1_d;
      solid1_q <= bus.solid;
      et1_q    <= e_t;
      eb1_q    <= e_b;
      el1_q    <= e_l;
      er1_q    <= e_r;
    end
  end

  // Stage 2: registered ball pixel, blanked collision and per-edge flags
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      ball_pixel_q <= 1'b0;
      collision_q  <= 1'b0;
      top_q        <= 1'b0;
      bottom_q     <= 1'b0;
      left_q       <= 1'b0;
      right_q      <= 1'b0;
    end else begin
      ball_pixel_q <= hit1_q;
      collision_q  <= collision_d;
      top_q        <= collision_d & et1_q;
      bottom_q     <= collision_d & eb1_q;
      left_q       <= collision_d & el1_q;
      right_q      <= collision_d & er1_q;
    end
  end

  assign bus.ball_pixel      = ball_pixel_q;
  assign bus.collision       = collision_q;
  assign bus.ball_top_col    = top_q;
  assign bus.ball_bottom_col = bottom_q;
  assign bus.ball_left_col   = left_q;
  assign bus.ball_right_col  = right_q;

endmodule
`default_nettype wire

// File: doc/ball_collision_detect.md
# ball_collision_detect

Pixel-rate collision detector that sits directly upstream of the ball motion block. It compares the raster position against a frame-stable copy of the ball position and the playfield "solid" pixel stream, then produces the ball video pixel, a collision strobe and per-edge collision flags. The motion block latches those flags during the frame and evaluates them at `frame_pulse`.

## Interface
Parameters:
- `BALL_SIZE`, default 4: ball width and height in pixels; must be 2..8.

Ports:
- `clk` in 1: pixel clock.
- `nRst` in 1: reset, asynchronous, active-low.
- `frame_pulse` in 1: one-cycle end-of-frame strobe, shared with the motion block.
- `pixel_valid` in 1: raster is in the visible area.
- `pixel_x` in 10: current raster column.
- `pixel_y` in 9: current raster row.
- `solid` in 1: playfield (wall, brick or paddle) occupies `pixel_x`,`pixel_y`; aligned with the coordinates in the same cycle.
- `ball_x` in 10: ball top-left column from the motion block.
- `ball_y` in 9: ball top-left row from the motion block.
- `ball_pixel` out 1: ball occupies the pixel presented 2 cycles earlier.
- `collision` out 1: a ball pixel overlaps `solid`.
- `ball_top_col` out 1: that overlap is on ball row 0.
- `ball_bottom_col` out 1: that overlap is on ball row `BALL_SIZE-1`.
- `ball_left_col` out 1: that overlap is on ball column 0.
- `ball_right_col` out 1: that overlap is on ball column `BALL_SIZE-1`.

## Operation
- **Shadow position.** `frame_pulse` is registered into `fp_d`. While `fp_d` is 1, `ball_x`/`ball_y` load into `sx`/`sy`. This is the cycle after the motion block updates, so the new position is used. `sx`/`sy` stay constant for the rest of the frame, so there is no tearing.
- **Stage 1 (registered).**
  - `dx = {1'b0,pixel_x} - {1'b0,sx}` and `dy = {1'b0,pixel_y} - {1'b0,sy}`, 11 and 10 bits.
  - `in_x` = no borrow and `dx < BALL_SIZE`; `in_y` likewise.
  - No wrap-around: a ball whose box extends past column 1023 or row 511 is simply clipped.
  - Edge flags: `e_t = (dy==0)`, `e_b = (dy==BALL_SIZE-1)`, `e_l = (dx==0)`, `e_r = (dx==BALL_SIZE-1)`.
  - `hit1 = pixel_valid & in_x & in_y`.
  - `solid` is registered alongside.
- **Stage 2 (registered outputs).**
  - `ball_pixel = hit1`.
  - `collision = hit1 & solid_d & ~blank`.
  - Each edge output = `collision` AND its edge flag.
  - A corner pixel asserts two edge flags simultaneously.
- **Blanking window.** `blank` is 1 while `frame_pulse`, `fp_d`, or either pipeline-delayed copy is 1. Collisions inside the window are dropped, because the motion block clears its latches on `frame_pulse`.
- **Reset.** All outputs 0, `sx`/`sy` = 0, pipeline = 0, `fp_d` = 0. After reset the shadow loads on the first `fp_d`. Until then the ball is treated as at (0,0).
- **`pixel_valid` low.** Forces `ball_pixel` and `collision` to 0 two cycles later.

## Timing
- Latency: 2 cycles from `pixel_x`/`pixel_y`/`solid` to every output.
- Throughput: one pixel per cycle, no stalls, no handshake.
- Outputs are per-pixel levels; consecutive overlapping pixels keep `collision` high on consecutive cycles.
- `frame_pulse` and `ball_x` changes in the same cycle: the shadow takes the value present during `fp_d`.
- Reset asserted mid-frame: outputs drop asynchronously to 0.
- Reset released mid-frame: detection uses (0,0) until the next frame.

## Configuration
- `BALL_COL_CORNER_MASK_EN`
  - Defined: the four ball corner pixels (two edge flags set) are excluded from `ball_pixel` and `collision`, giving a rounded ball. Corner-only overlaps produce no collision.
  - Undefined: the full square is used and corner overlaps assert two edge flags.

## Test plan
- **Edge hits.** `BALL_SIZE`=4, shadow (100,200), `solid` only at (101,200): at the cycle the pixel is presented+2, `collision`=1 and `ball_top_col`=1; the other edge outputs stay 0.
- **Corner hit.** `solid` at (103,203), macro undefined: `collision`, `ball_bottom_col` and `ball_right_col` all 1. With the macro defined: all outputs 0 and `ball_pixel`=0 at that pixel.
- **Frame-stable shadow.** `ball_x` changes 100→140 mid-frame: `ball_pixel` stays at columns 100..103 until after the next `frame_pulse`, then moves to 140..143.
- **Blanking.** A `solid` overlap presented in the `frame_pulse` cycle and in the following cycle produces no `collision`. An identical overlap 4 cycles later produces `collision`=1.
- **Boundaries.**
  - `ball_x`=1022: only columns 1022 and 1023 give `ball_pixel`=1; column 0 gives 0.
  - Reset pulsed mid-frame: all outputs are 0 within the reset window.
  - `pixel_valid`=0 over the ball: `ball_pixel`=0.
